// File: rtl/keypad_scan_controller_if.sv
// Key event handshake between the keypad scan controller (master) and the calculator core (slave).
interface keypad_scan_controller_if;
  logic       key_valid;
  logic       key_ready;
  logic [3:0] key_code;
  logic [7:0] key_raw;

  modport master (output key_valid, output key_code, output key_raw, input key_ready);
  modport slave  (input key_valid, input key_code, input key_raw, output key_ready);
endinterface

// File: rtl/keypad_scan_controller.sv
// 4x4 keypad column scanner with press/release debounce and a 4-deep key event FIFO.
module keypad_scan_controller #(
  parameter int SCAN_DIV        = 1000,
  parameter int DEBOUNCE_CYCLES = 20000
) (
  input  logic                            clock,
  input  logic                            reset_n,
  input  logic [3:0]                      row,
  output logic [3:0]                      col,
  keypad_scan_controller_if.master        key_if,
  output logic                            key_held,
  output logic                            overflow
);

  localparam int CNT_MAX = (SCAN_DIV > DEBOUNCE_CYCLES) ? SCAN_DIV : DEBOUNCE_CYCLES;
  localparam int CW      = $clog2(CNT_MAX);
  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
  // Nibble {r,c} holds the hex code for row r, column c.
  localparam logic [63:0] KEY_MAP = 64'hDF0E_C987_B654_A321;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  state_t          state_r;
  logic [3:0]      row_meta_r;
  logic [3:0]      srow_r;
  logic [1:0]      n_r;
  logic [3:0]      col_r;
  logic [CW-1:0]   cnt_r;
  logic [7:0]      raw_lat_r;
  logic            held_r;
  logic [11:0]     mem_r [4];
  logic [1:0]      wr_ptr_r;
  logic [1:0]      rd_ptr_r;
  logic [2:0]      count_r;
  logic            overflow_r;
  logic            push_s;
  logic            pop_s;
  logic            full_s;
  logic            do_push_s;
  logic [11:0]     push_data_s;

  function automatic logic [3:0] key_lookup(input logic [3:0] srow, input logic [1:0] c);
    logic [1:0] r;
    if (!srow[0])      r = 2'd0;
    else if (!srow[1]) r = 2'd1;
    else if (!srow[2]) r = 2'd2;
    else               r = 2'd3;
    return KEY_MAP[{r, c, 2'b00} +: 4];
  endfunction

  // Two-flop synchronizer for the asynchronous row inputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      row_meta_r <= 4'hF;
      srow_r     <= 4'hF;
    end else begin
      row_meta_r <= row;
      srow_r     <= row_meta_r;
    end
  end

  // Scan / debounce sequencer; one shared counter serves dwell and debounce timing.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= SCAN;
      n_r       <= 2'd0;
      col_r     <= 4'b1110;
      cnt_r     <= '0;
      raw_lat_r <= 8'h00;
      held_r    <= 1'b0;
    end else begin
      case (state_r)
        SCAN: begin
          if (cnt_r == SCAN_LAST) begin
            cnt_r <= '0;
            if (srow_r == 4'hF) begin
              n_r   <= n_r + 2'd1;
              col_r <= {col_r[2:0], col_r[3]};
            end else begin
              raw_lat_r <= {col_r, srow_r};
              state_r   <= DEBOUNCE;
            end
          end else begin
            cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
          end
        end
        DEBOUNCE: begin
          if (srow_r != raw_lat_r[3:0]) begin
            state_r <= SCAN;
            cnt_r   <= '0;
          end else if (cnt_r == DB_LAST) begin
            state_r <= PRESSED;
            held_r  <= 1'b1;
            cnt_r   <= '0;
          end else begin
            cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
          end
        end
        PRESSED: begin
          if (srow_r == 4'hF) begin
            state_r <= RELEASE;
            cnt_r   <= '0;
          end else begin
            state_r <= PRESSED;
          end
        end
        RELEASE: begin
          if (srow_r != 4'hF) begin
            state_r <= PRESSED;
            cnt_r   <= '0;
          end else if (cnt_r == DB_LAST) begin
            state_r <= SCAN;
            cnt_r   <= '0;
            n_r     <= n_r + 2'd1;
            col_r   <= {col_r[2:0], col_r[3]};
            held_r  <= 1'b0;
          end else begin
            cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          state_r <= SCAN;
          cnt_r   <= '0;
          held_r  <= 1'b0;
        end
      endcase
    end
  end

  assign push_s      = (state_r == DEBOUNCE) && (srow_r == raw_lat_r[3:0]) && (cnt_r == DB_LAST);
  assign push_data_s = {key_lookup(raw_lat_r[3:0], n_r), raw_lat_r};
  assign full_s      = (count_r == 3'd4);
  assign pop_s       = (count_r != 3'd0) && key_if.key_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push_s   = push_s && (!full_s || pop_s);

  // Event FIFO storage, pointers, occupancy and overflow pulse.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) mem_r[i] <= 12'h000;
      wr_ptr_r   <= 2'd0;
      rd_ptr_r   <= 2'd0;
      count_r    <= 3'd0;
      overflow_r <= 1'b0;
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= push_data_s;
        wr_ptr_r        <= wr_ptr_r + 2'd1;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + 2'd1;
      end
      if (do_push_s && !pop_s) begin
        count_r <= count_r + 3'd1;
      end else if (!do_push_s && pop_s) begin
        count_r <= count_r - 3'd1;
      end else begin
        count_r <= count_r;
      end
      overflow_r <= push_s && full_s && !pop_s;
    end
  end

  assign col              = col_r;
  assign key_held         = held_r;
  assign overflow         = overflow_r;
  assign key_if.key_valid = (count_r != 3'd0);
  assign key_if.key_code  = mem_r[rd_ptr_r][11:8];
  assign key_if.key_raw   = mem_r[rd_ptr_r][7:0];

endmodule

// File: tb/tb_keypad_scan_controller.sv
// Scoreboard bench for keypad_scan_controller with a behavioural 4x4 keypad matrix.
module tb_keypad_scan_controller;
  logic       clock;
  logic       reset_n;
  logic [3:0] row;
  logic [3:0] col;
  logic       key_held;
  logic       overflow;
  logic [3:0] key_mask [4];

  int n_checks;
  int n_errors;
  int valid_cycles;
  int ovf_cnt;
  logic [11:0] exp_q [$];

  keypad_scan_controller_if kif ();

  keypad_scan_controller #(.SCAN_DIV(4), .DEBOUNCE_CYCLES(8)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .row      (row),
    .col      (col),
    .key_if   (kif),
    .key_held (key_held),
    .overflow (overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Keypad matrix: a pressed key pulls its row low while its column is driven low.
  always_comb begin
    row = 4'hF;
    for (int c = 0; c < 4; c++) begin
      if (!col[c]) row = row & ~key_mask[c];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Output monitor: compares every popped head against the scoreboard.
  always @(negedge clock) begin
    if (reset_n) begin
      if (kif.key_valid) valid_cycles++;
      if (overflow) ovf_cnt++;
      if (kif.key_valid && kif.key_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_event", {20'd0, kif.key_code, kif.key_raw}, 32'd0);
        end else begin
          logic [11:0] e;
          e = exp_q.pop_front();
          chk("key_code", {28'd0, kif.key_code}, {28'd0, e[11:8]});
          chk("key_raw", {24'd0, kif.key_raw}, {24'd0, e[7:0]});
        end
      end
    end
  end

  task automatic wait_held(input logic lvl, input string tag);
    int k;
    k = 0;
    while (key_held !== lvl && k < 200) begin
      @(negedge clock);
      k++;
    end
    chk(tag, {31'd0, key_held}, {31'd0, lvl});
  endtask

  task automatic press(input int c, input logic [3:0] mask, input logic [3:0] code, input bit expect_evt);
    logic [3:0] cdrv;
    cdrv = 4'b0001 << c;
    if (expect_evt) exp_q.push_back({code, ~cdrv, ~mask});
    key_mask[c] = mask;
    wait_held(1'b1, "held_rise");
    key_mask[c] = 4'h0;
    wait_held(1'b0, "held_fall");
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_col"}, {28'd0, col}, 32'h0000_000E);
    chk({tag, "_valid"}, {31'd0, kif.key_valid}, 32'd0);
    chk({tag, "_code"}, {28'd0, kif.key_code}, 32'd0);
    chk({tag, "_raw"}, {24'd0, kif.key_raw}, 32'd0);
    chk({tag, "_held"}, {31'd0, key_held}, 32'd0);
    chk({tag, "_ovf"}, {31'd0, overflow}, 32'd0);
  endtask

  initial begin
    logic [3:0] col_seq [4];
    int k;
    int saved;
    n_checks = 0;
    n_errors = 0;
    valid_cycles = 0;
    ovf_cnt = 0;
    for (int c = 0; c < 4; c++) key_mask[c] = 4'h0;
    kif.key_ready = 1'b1;
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    check_reset_outputs("rst");
    reset_n = 1'b1;

    // Idle scan: column advances every 4 cycles and wraps.
    col_seq[0] = 4'b1101; col_seq[1] = 4'b1011; col_seq[2] = 4'b0111; col_seq[3] = 4'b1110;
    for (int i = 0; i < 4; i++) begin
      repeat (3) @(negedge clock);
      chk("idle_held", {31'd0, key_held}, 32'd0);
      @(negedge clock);
      chk("idle_col", {28'd0, col}, {28'd0, col_seq[i]});
    end
    chk("idle_valid_cycles", valid_cycles, 32'd0);

    // Long press col2/row1 with consumer ready.
    valid_cycles = 0;
    exp_q.push_back({4'h6, 8'hBD});
    key_mask[2] = 4'b0010;
    repeat (60) @(negedge clock);
    chk("hold_held", {31'd0, key_held}, 32'd1);
    key_mask[2] = 4'h0;
    k = 0;
    while (key_held && k < 50) begin
      @(negedge clock);
      k++;
    end
    chk("release_latency", k, 32'd11);
    chk("resume_col3", {28'd0, col}, 32'h0000_0007);
    chk("single_valid", valid_cycles, 32'd1);

    // Bounce on col2/row1 shorter than the debounce window.
    valid_cycles = 0;
    k = 0;
    while (col !== 4'b1011 && k < 40) begin
      @(negedge clock);
      k++;
    end
    chk("bounce_col2_seen", {28'd0, col}, 32'h0000_000B);
    key_mask[2] = 4'b0010;
    repeat (5) @(negedge clock);
    key_mask[2] = 4'h0;
    repeat (3) @(negedge clock);
    chk("bounce_col_hold", {28'd0, col}, 32'h0000_000B);
    chk("bounce_held", {31'd0, key_held}, 32'd0);
    repeat (4) @(negedge clock);
    chk("bounce_next_col", {28'd0, col}, 32'h0000_0007);
    repeat (10) @(negedge clock);
    chk("bounce_no_event", valid_cycles, 32'd0);

    // Two low rows on col0: lowest row wins, raw keeps both.
    press(0, 4'b1001, 4'h1, 1'b1);
    repeat (3) @(negedge clock);

    // Five presses with the consumer stalled: fifth is dropped.
    kif.key_ready = 1'b0;
    ovf_cnt = 0;
    press(0, 4'b0001, 4'h1, 1'b1);
    press(1, 4'b0010, 4'h5, 1'b1);
    press(2, 4'b0100, 4'h9, 1'b1);
    press(3, 4'b1000, 4'hD, 1'b1);
    chk("full_no_ovf", ovf_cnt, 32'd0);
    press(1, 4'b1000, 4'h0, 1'b0);
    chk("ovf_once", ovf_cnt, 32'd1);
    chk("stall_valid", {31'd0, kif.key_valid}, 32'd1);
    kif.key_ready = 1'b1;
    repeat (8) @(negedge clock);
    chk("drain_q_empty", exp_q.size(), 32'd0);
    chk("drain_valid", {31'd0, kif.key_valid}, 32'd0);

    // Reset during debounce.
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    key_mask[0] = 4'b0001;
    repeat (8) @(negedge clock);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("rst_deb");
    key_mask[0] = 4'h0;
    @(negedge clock);
    saved = valid_cycles;
    reset_n = 1'b1;
    repeat (30) @(negedge clock);
    chk("rst_deb_no_event", valid_cycles - saved, 32'd0);

    // Reset during release debounce.
    exp_q.push_back({4'h8, 8'hDB});
    key_mask[1] = 4'b0100;
    wait_held(1'b1, "rel_held_rise");
    key_mask[1] = 4'h0;
    repeat (6) @(negedge clock);
    chk("rel_still_held", {31'd0, key_held}, 32'd1);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("rst_rel");
    @(negedge clock);
    saved = valid_cycles;
    reset_n = 1'b1;
    repeat (30) @(negedge clock);
    chk("rst_rel_no_event", valid_cycles - saved, 32'd0);
    chk("rst_rel_held", {31'd0, key_held}, 32'd0);
    chk("final_q_empty", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/keypad_scan_controller.md
# keypad_scan_controller

Sequencing controller for the 4x4 calculator keypad. It drives the active-low column lines, samples the row lines, and debounces both press and release with a cycle timer. Each accepted keypress becomes exactly one event in a 4-deep key FIFO that the calculator core drains with a valid/ready handshake. It replaces free-running column cycling and provides the debounced key strobe the input path needs.

## Interface
- SCAN_DIV, 1000: clock cycles each column is driven before its rows are sampled; legal range ≥ 4.
- DEBOUNCE_CYCLES, 20000: consecutive stable cycles required to accept a press or a release; legal range ≥ 2.
- clock  in  1  system clock, all logic on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- row  in  4  keypad rows, active-low (pulled up), asynchronous to clock.
- col  out  4  column drive, exactly one bit low at all times.
- key_valid  out  1  FIFO not empty; key_code/key_raw describe the head entry.
- key_ready  in  1  consumer pop; the head is popped on any cycle where key_valid && key_ready.
- key_code  out  4  hex code of the head key.
- key_raw  out  8  {col, row} pattern latched at detection for the head key.
- key_held  out  1  high while an accepted key has not yet been debounced as released.
- overflow  out  1  one-cycle pulse when a key event is dropped because the FIFO is full.

## Operation
- Row input passes through a 2-flop synchronizer that resets to 4'hF. All state decisions use the synchronized value (srow).
- Column index n (0..3) drives col = ~(1<<n).
- Key code mapping, with r the row index and c the column index:
  - r0: c0..3 → 1, 2, 3, A
  - r1: 4, 5, 6, B
  - r2: 7, 8, 9, C
  - r3: E, 0, F, D
- Multiple low rows: the lowest row index selects the code. key_raw keeps the full pattern.
- FSM states and transitions:
  - SCAN: the dwell counter counts 0..SCAN_DIV-1.
    - At SCAN_DIV-1, if srow == 4'hF: n ← n+1 (mod 4, wraps 3→0), counter ← 0.
    - Otherwise: latch {col, srow} and go to DEBOUNCE. n is unchanged.
  - DEBOUNCE: col is held. The counter increments on each cycle with srow == latched row.
    - Any mismatch: return to SCAN with the same n and dwell counter ← 0. No event.
    - When the counter reaches DEBOUNCE_CYCLES-1: push the event and go to PRESSED.
  - PRESSED: key_held = 1 and col is held. When srow == 4'hF, go to RELEASE with counter ← 0. Row changes while not all-high are ignored.
  - RELEASE: the counter increments on each cycle with srow == 4'hF.
    - Any low row: return to PRESSED.
    - When the counter reaches DEBOUNCE_CYCLES-1: go to SCAN with n ← n+1 and dwell counter ← 0. key_held drops.
- FIFO: 4 entries of {code, raw}.
  - Push when full and no pop in the same cycle: entry dropped, overflow pulses, contents unchanged.
  - Push and pop in the same cycle when full: both are performed, no overflow.
  - Pop when empty: ignored.
  - Entries are delivered in order.

## Timing
- Reset values:
  - col = 4'b1110, n = 0, state SCAN, all counters 0.
  - key_valid = 0, key_code = 0, key_raw = 8'h00, key_held = 0, overflow = 0, FIFO empty.
- Reset is asynchronous at any point, including mid-debounce or mid-release. No event is generated and state does not survive reset.
- Row-to-decision latency is 2 cycles (synchronizer).
- The push happens on the cycle the debounce counter reaches DEBOUNCE_CYCLES-1. key_valid and key_held rise on the following edge.
- The pop takes effect on the edge where key_valid && key_ready. The next entry, or key_valid = 0, is visible on the following cycle.
- Worst-case press-to-event latency: 2 + 4·SCAN_DIV + DEBOUNCE_CYCLES cycles.
- overflow is high for exactly one cycle per dropped event.

## Test plan
All scenarios use SCAN_DIV=4 and DEBOUNCE_CYCLES=8.
- Reset release, no keys → col steps 1110, 1101, 1011, 0111 every 4 cycles and wraps to 1110. All outputs stay at their reset values.
- Hold col2/row1 for 60 cycles, key_ready=1 → exactly one key_valid cycle with key_code=6 and key_raw=8'hBD. key_held is high until 8 stable released cycles after release, then scanning resumes at col3.
- Row1 low on col2 for 5 cycles, then high (bounce) → no event, key_held stays 0, scanning continues from col2.
- Rows 0 and 3 low together on col0 → key_code=1, key_raw=8'hE6.
- key_ready=0 and 5 distinct presses → key_valid held high, overflow pulses once on the 5th push. Draining yields the first 4 codes in order.
- Assert reset_n mid-DEBOUNCE and mid-RELEASE → all outputs return to reset values immediately. No event after reset is released.
